// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock with per-bit valid and first/last framing.
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_first,
    output logic             s_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_out_q, s_out_d;
    logic             s_first_q, s_first_d;
    logic             last_bit;
    logic             accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            s_out_q   <= IDLE_LEVEL;
            s_first_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
            s_first_q <= s_first_d;
        end
    end

    always_comb begin
        last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        p_ready   = rst && ((state_q == IDLE) || last_bit);
        accept    = p_valid && p_ready;

        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        s_out_d   = s_out_q;
        s_first_d = 1'b0;

        // The first bit goes straight to s_out_q; shreg keeps only the remaining bits.
        if (accept) begin
            state_d   = SHIFT;
            cnt_d     = '0;
            s_first_d = 1'b1;
            if (MSB_FIRST) begin
                s_out_d = p_in[WIDTH-1];
                shreg_d = p_in << 1;
            end else begin
                s_out_d = p_in[0];
                shreg_d = p_in >> 1;
            end
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
                s_out_d = IDLE_LEVEL;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (MSB_FIRST) begin
                    s_out_d = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    s_out_d = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
        end
    end

    assign s_out   = s_out_q;
    assign s_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT);
    assign s_first = s_first_q;
    assign s_last  = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first 4-bit, LSB-first 4-bit
// and 1-bit instances, expected bits queued at drive time and popped per valid cycle.
module tb_piso_serializer;

    logic       clk;
    logic       rst;

    logic [3:0] p_in_a;
    logic       p_valid_a, p_ready_a, s_out_a, s_valid_a, s_first_a, s_last_a, busy_a;
    logic [3:0] p_in_b;
    logic       p_valid_b, p_ready_b, s_out_b, s_valid_b, s_first_b, s_last_b, busy_b;
    logic [0:0] p_in_c;
    logic       p_valid_c, p_ready_c, s_out_c, s_valid_c, s_first_c, s_last_c, busy_c;

    typedef struct packed {
        logic d;
        logic first;
        logic last;
    } bit_t;

    bit_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .p_in(p_in_a), .p_valid(p_valid_a), .p_ready(p_ready_a),
        .s_out(s_out_a), .s_valid(s_valid_a), .s_first(s_first_a), .s_last(s_last_a),
        .busy(busy_a)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .p_in(p_in_b), .p_valid(p_valid_b), .p_ready(p_ready_b),
        .s_out(s_out_b), .s_valid(s_valid_b), .s_first(s_first_b), .s_last(s_last_b),
        .busy(busy_b)
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .p_in(p_in_c), .p_valid(p_valid_c), .p_ready(p_ready_c),
        .s_out(s_out_c), .s_valid(s_valid_c), .s_first(s_first_c), .s_last(s_last_c),
        .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_word(input logic [3:0] w, input int width, input bit msb);
        for (int i = 0; i < width; i++) begin
            int idx;
            bit_t b;
            idx = msb ? (width - 1 - i) : i;
            b.d = w[idx];
            b.first = (i == 0);
            b.last = (i == width - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic test_reset();
        #2;
        tests_run++;
        if ({s_out_a, s_valid_a, s_first_a, s_last_a, busy_a, p_ready_a} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_a: got %b expected 000000",
                     {s_out_a, s_valid_a, s_first_a, s_last_a, busy_a, p_ready_a});
        end
        tests_run++;
        if ({p_ready_b, s_valid_b, p_ready_c, s_valid_c} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_bc: got %b expected 0000",
                     {p_ready_b, s_valid_b, p_ready_c, s_valid_c});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({p_ready_a, p_ready_b, p_ready_c} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 111",
                     {p_ready_a, p_ready_b, p_ready_c});
        end
    endtask

    task automatic test_single(input logic [3:0] w, input string name);
        bit_t e;
        @(negedge clk);
        p_in_a = w;
        p_valid_a = 1'b1;
        push_word(w, 4, 1'b1);
        tests_run++;
        if (p_ready_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ready: got %b expected 1", name, p_ready_a);
        end
        @(negedge clk);
        p_valid_a = 1'b0;
        p_in_a = ~w;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if ({s_out_a, s_valid_a, s_first_a, s_last_a} !== {e.d, 1'b1, e.first, e.last}) begin
                tests_failed++;
                $display("FAIL %s_bit%0d: got %b expected %b", name, k,
                         {s_out_a, s_valid_a, s_first_a, s_last_a}, {e.d, 1'b1, e.first, e.last});
            end
            @(negedge clk);
        end
        tests_run++;
        if ({s_out_a, s_valid_a, busy_a, p_ready_a} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL %s_idle: got %b expected 0001", name,
                     {s_out_a, s_valid_a, busy_a, p_ready_a});
        end
    endtask

    task automatic test_back_to_back();
        bit_t e;
        @(negedge clk);
        p_in_a = 4'b1011;
        p_valid_a = 1'b1;
        push_word(4'b1011, 4, 1'b1);
        tests_run++;
        if (p_ready_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_E: got %b expected 1", p_ready_a);
        end
        @(negedge clk);
        p_in_a = 4'b0110;
        push_word(4'b0110, 4, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) p_valid_a = 1'b0;
            e = exp_q.pop_front();
            tests_run++;
            if ({s_out_a, s_valid_a, s_first_a, s_last_a} !== {e.d, 1'b1, e.first, e.last}) begin
                tests_failed++;
                $display("FAIL b2b_bit%0d: got %b expected %b", k,
                         {s_out_a, s_valid_a, s_first_a, s_last_a}, {e.d, 1'b1, e.first, e.last});
            end
            tests_run++;
            if (p_ready_a !== ((k == 4) || (k == 8))) begin
                tests_failed++;
                $display("FAIL b2b_ready%0d: got %b expected %b", k, p_ready_a,
                         ((k == 4) || (k == 8)));
            end
            @(negedge clk);
        end
        tests_run++;
        if ({s_valid_a, busy_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_idle: got %b expected 00", {s_valid_a, busy_a});
        end
    endtask

    task automatic test_loopback();
        bit_t e;
        logic [3:0] sipo;
        sipo = 4'b0000;
        @(negedge clk);
        p_in_a = 4'b1001;
        p_valid_a = 1'b1;
        push_word(4'b1001, 4, 1'b1);
        @(negedge clk);
        p_valid_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            if (s_valid_a) sipo = {sipo[2:0], s_out_a};
            tests_run++;
            if (s_out_a !== e.d) begin
                tests_failed++;
                $display("FAIL loop_bit%0d: got %b expected %b", k, s_out_a, e.d);
            end
            @(negedge clk);
        end
        tests_run++;
        if (sipo !== 4'b1001) begin
            tests_failed++;
            $display("FAIL loop_sipo: got %b expected 1001", sipo);
        end
    endtask

    task automatic test_reset_mid_word();
        bit_t e;
        @(negedge clk);
        p_in_a = 4'b1111;
        p_valid_a = 1'b1;
        push_word(4'b1111, 4, 1'b1);
        @(negedge clk);
        p_valid_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if ({s_out_a, s_valid_a, s_first_a} !== {e.d, 1'b1, e.first}) begin
                tests_failed++;
                $display("FAIL midrst_bit%0d: got %b expected %b", k,
                         {s_out_a, s_valid_a, s_first_a}, {e.d, 1'b1, e.first});
            end
            @(negedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({s_out_a, s_valid_a, s_first_a, s_last_a, busy_a, p_ready_a} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL midrst_async: got %b expected 000000",
                     {s_out_a, s_valid_a, s_first_a, s_last_a, busy_a, p_ready_a});
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        test_single(4'b0011, "after_rst");
    endtask

    task automatic test_lsb_first();
        bit_t e;
        @(negedge clk);
        p_in_b = 4'b1011;
        p_valid_b = 1'b1;
        push_word(4'b1011, 4, 1'b0);
        @(negedge clk);
        p_valid_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            tests_run++;
            if ({s_out_b, s_valid_b, s_first_b, s_last_b, busy_b} !==
                {e.d, 1'b1, e.first, e.last, 1'b1}) begin
                tests_failed++;
                $display("FAIL lsb_bit%0d: got %b expected %b", k,
                         {s_out_b, s_valid_b, s_first_b, s_last_b, busy_b},
                         {e.d, 1'b1, e.first, e.last, 1'b1});
            end
            @(negedge clk);
        end
        tests_run++;
        if (s_valid_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL lsb_idle: got %b expected 0", s_valid_b);
        end
    endtask

    task automatic test_width1();
        bit_t e;
        logic val;
        val = 1'b1;
        @(negedge clk);
        p_in_c = val;
        p_valid_c = 1'b1;
        push_word({3'b000, val}, 1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({s_out_c, s_valid_c, s_first_c, s_last_c, p_ready_c, busy_c} !==
                {e.d, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
                tests_failed++;
                $display("FAIL w1_bit%0d: got %b expected %b", k,
                         {s_out_c, s_valid_c, s_first_c, s_last_c, p_ready_c, busy_c},
                         {e.d, 5'b11111});
            end
            val = ~val;
            if (k < 5) begin
                p_in_c = val;
                push_word({3'b000, val}, 1, 1'b1);
            end else begin
                p_valid_c = 1'b0;
            end
        end
        @(negedge clk);
        tests_run++;
        if ({s_valid_c, s_out_c} !== 2'b00) begin
            tests_failed++;
            $display("FAIL w1_idle: got %b expected 00", {s_valid_c, s_out_c});
        end
    endtask

    initial begin
        rst = 1'b0;
        p_in_a = '0;
        p_valid_a = 1'b0;
        p_in_b = '0;
        p_valid_b = 1'b0;
        p_in_c = '0;
        p_valid_c = 1'b0;

        test_reset();
        test_single(4'b1011, "single");
        test_back_to_back();
        test_loopback();
        test_reset_mid_word();
        test_lsb_first();
        test_width1();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
